// File: rtl/serial_pattern_detector_if.sv
// serial_pattern_detector_if: serial sample stream in, match status and debug window out
interface serial_pattern_detector_if #(
  parameter int LEN   = 4,
  parameter int CNT_W = 4
);
  logic             d_in;
  logic             d_valid;
  logic             clear;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             sat;
  logic [LEN-1:0]   window;
  modport master (output d_in, d_valid, clear, input match, match_count, sat, window);
  modport slave  (input d_in, d_valid, clear, output match, match_count, sat, window);
endinterface

// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: fill-gated shift-window pattern matcher with saturating match counter
module serial_pattern_detector #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_pattern_detector_if.slave bus
);
  localparam int FW = $clog2(LEN + 1);
  logic [LEN-1:0]   window_q, window_d, shifted;
  logic [FW-1:0]    fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d, match_q, hit;
  always_comb begin
    shifted  = {window_q[LEN-2:0], bus.d_in};
    fill_inc = (fill_q == FW'(LEN)) ? fill_q : fill_q + 1'b1;
    hit      = bus.d_valid && fill_inc == FW'(LEN) && shifted == PATTERN;
    window_d = bus.d_valid ? shifted : window_q;
    fill_d   = !bus.d_valid ? fill_q : (hit && OVERLAP == 0) ? '0 : fill_inc;
    cnt_d    = (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    sat_d    = sat_q | (hit && &cnt_q);
  end
  always_ff @(posedge clk) begin
    if (!reset || bus.clear) begin
      window_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      match_q  <= hit;
    end
  end
  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.sat         = sat_q;
  assign bus.window      = window_q;
endmodule

// File: doc/serial_pattern_detector.md
Name: serial_pattern_detector

Overview:
Downstream consumer of the serial bit stream produced by the D-from-T flip-flop stage. The block samples the flip-flop's q output and detects a fixed serial pattern, with optional overlapping matches. It reports each match as a single-cycle pulse, keeps a saturating match counter and exposes the current bit window for debug.

Parameters:
LEN, 4, pattern length in bits (2..16).
PATTERN, 4'b1011, pattern to detect; MSB is the oldest bit, LSB the newest.
OVERLAP, 1, 1 = matches may share bits; 0 = history is discarded after each match.
CNT_W, 4, width of the match counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset.
d_in  input  1  serial data bit (the upstream flip-flop's q).
d_valid  input  1  d_in is sampled only on edges where this is high.
clear  input  1  synchronous soft clear, active-high.
match  output  1  one-cycle pulse when the pattern completes.
match_count  output  CNT_W  saturating count of matches.
sat  output  1  sticky flag: a match arrived while match_count was at maximum.
window  output  LEN  last LEN sampled bits; LSB is the newest.

Behaviour:
- All state updates on the rising edge of clk. There is no asynchronous path.
- Priority per edge, highest first: reset low, then clear high, then d_valid high, then hold.
- Reset (reset==0 at an edge):
  - match=0, match_count=0, sat=0, window=0, internal fill counter=0.
  - Applies regardless of d_valid or clear.
- Clear (reset==1, clear==1):
  - Same effect as reset.
  - A sample presented in the same cycle is discarded.
- Sample (d_valid==1):
  - window <= {window[LEN-2:0], d_in}.
  - fill <= min(fill+1, LEN); fill is $clog2(LEN+1) bits wide.
- Match condition, evaluated on the post-shift value: fill_next==LEN && window_next==PATTERN.
  - Leading zeros of the reset window never count, because fill gates the compare.
- Match latency: match rises at the same edge that shifts in the completing bit. It is high for exactly one cycle and falls at the next edge, whatever d_valid is then.
- On a match:
  - If match_count < 2^CNT_W-1: match_count increments.
  - Otherwise match_count holds and sat is set to 1.
  - sat stays set until reset or clear.
- OVERLAP=1: fill stays at LEN, so the next sample may complete another match.
- OVERLAP=0: fill is set to 0 on the matching edge. window still shows the shifted value, but LEN fresh samples are required before the next match.
- d_valid==0: window, fill, match_count and sat hold; match is 0.
- Reset or clear in the middle of a partial pattern abandons it. No match may be produced from bits sampled before the clear.
- Outputs are registered only, with no combinational path from inputs to outputs.
- Implementation style: one state register set and one next-state block. A Moore-style FSM is optional, not required.

Test Plan:
(LEN=4, PATTERN=4'b1011, CNT_W=4 unless stated)
1. reset=0 for 2 edges with d_valid=1, d_in=1 -> match=0, match_count=0, sat=0, window=0.
2. Valid bits 1,0,1,1 -> match high for exactly the cycle after the 4th sample edge; match_count=1; window=4'b1011.
3. Valid bits 1,0,1,1,0,1,1 -> OVERLAP=1: two pulses, at the 4th and 7th samples, match_count=2. OVERLAP=0: one pulse, match_count=1.
4. Bits 1,0, then d_valid=0 for 3 cycles, then 1,1 -> one match after the final sample. match stays 0 during the gap and window holds 4'b0010 through it.
5. 16 back-to-back 1011 groups (OVERLAP=0) -> after the 15th match: match_count=15, sat=0. After the 16th: match_count=15, sat=1, match still pulses.
6. Bits 1,0,1, then clear=1 with d_valid=1, d_in=1 -> no match, all outputs 0. Then 1,0,1,1 -> match, match_count=1. Repeat the sequence using reset=0 instead of clear -> identical results.
